// File: rtl/rr_dist_pkg.sv
// Shared constants and the skip-full channel scan for the round-robin distributor.
package rr_dist_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [CH_W-1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2,
        CH_D = 2'd3
    } ch_e;

    // Returns {found, channel}: first non-full channel scanning ptr, ptr+1, ... (mod NUM_CH).
    function automatic logic [CH_W:0] scan_free(input logic [CH_W-1:0] ptr,
                                                input logic [NUM_CH-1:0] full);
        logic [CH_W-1:0] idx;
        logic [CH_W-1:0] sel;
        logic            found;
        found = 1'b0;
        sel   = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = ptr + CH_W'(k);
            if (!found && !full[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

endpackage

// File: rtl/rr_fifo_channel.sv
// One per-channel FIFO with a registered read port; full/empty come from the registered count.
module rr_fifo_channel
    import rr_dist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_pop_data;
    logic              r_pop_valid;
    logic              w_push_eff;
    logic              w_pop_eff;

    assign full       = (r_count == CNT_W'(DEPTH));
    assign empty      = (r_count == '0);
    // Flags reflect the pre-edge state: a same-cycle read never frees room for a write and vice versa.
    assign w_push_eff = push && !full;
    assign w_pop_eff  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push_eff) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_eff) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop_eff) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push_eff, w_pop_eff})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
        end else if (pop) begin
            r_pop_data  <= w_pop_eff ? r_mem[r_rd_ptr] : '0;
            r_pop_valid <= w_pop_eff;
        end else begin
            r_pop_valid <= 1'b0;
        end
    end

    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;

endmodule

// File: rtl/round_robin_fifo_distributor.sv
// Deals a single write stream round-robin into four channel FIFOs, skipping full channels.
// Handshake: a word is taken whenever wen=1 and ready=1; with ready=0 the word is dropped and error pulses.
module round_robin_fifo_distributor
    import rr_dist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [DATA_W-1:0] din,
    input  logic [NUM_CH-1:0] ren,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic [NUM_CH-1:0] valid,
    output logic              ready,
    output logic              error,
    output logic [CH_W-1:0]   dbg_ptr
);

    logic [CH_W-1:0]   r_ptr;
    logic              r_error;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop_valid;
    logic [DATA_W-1:0] w_pop_data [NUM_CH];
    logic [CH_W:0]     w_scan;
    logic              w_found;
    logic [CH_W-1:0]   w_sel;

    assign w_scan  = scan_free(r_ptr, w_full);
    assign w_found = w_scan[CH_W];
    assign w_sel   = w_scan[CH_W-1:0];

    always_comb begin
        w_push = '0;
        if (wen && w_found) begin
            w_push[w_sel] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rr_fifo_channel #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (w_push[g]),
            .push_data (din),
            .pop       (ren[g]),
            .pop_data  (w_pop_data[g]),
            .pop_valid (w_pop_valid[g]),
            .full      (w_full[g]),
            .empty     (w_empty[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= CH_A;
            r_error <= 1'b0;
        end else begin
            r_error <= wen && !w_found;
            if (wen && w_found) begin
                r_ptr <= w_sel + CH_W'(1);
            end
        end
    end

    // Only registered counts feed ready, so there is no wen/ren-to-ready path.
    assign ready   = ~&w_full;
    assign error   = r_error;
    assign dbg_ptr = r_ptr;
    assign valid   = w_pop_valid;
    assign a       = w_pop_data[CH_A];
    assign b       = w_pop_data[CH_B];
    assign c       = w_pop_data[CH_C];
    assign d       = w_pop_data[CH_D];

endmodule

// File: tb/tb_round_robin_fifo_distributor.sv
// Directed bench for round_robin_fifo_distributor with hand-computed expectations.
module tb_round_robin_fifo_distributor;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic [7:0] din;
    logic [3:0] ren;
    logic [7:0] a, b, c, d;
    logic [3:0] valid;
    logic       ready;
    logic       error;
    logic [1:0] dbg_ptr;

    int n_chk;
    int n_err;

    round_robin_fifo_distributor #(.DATA_W(8), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wen     (wen),
        .din     (din),
        .ren     (ren),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .valid   (valid),
        .ready   (ready),
        .error   (error),
        .dbg_ptr (dbg_ptr)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge, then return 1 ns after the next rising edge.
    task automatic step(input logic w, input logic [7:0] dv, input logic [3:0] r);
        @(negedge clk);
        wen = w;
        din = dv;
        ren = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wen   = 1'b0;
        din   = '0;
        ren   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_c [4];
        logic [7:0] exp_b [4];
        n_chk = 0;
        n_err = 0;
        wen   = 1'b0;
        din   = '0;
        ren   = '0;
        rst_n = 1'b0;
        #12;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_a", 32'(a), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ptr", 32'(dbg_ptr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // empty read
        step(1'b0, 8'd0, 4'b0001);
        check("empty_valid", 32'(valid), 32'd0);
        check("empty_a", 32'(a), 32'd0);

        // basic deal
        step(1'b1, 8'd10, 4'b0000);
        check("deal_ptr1", 32'(dbg_ptr), 32'd1);
        step(1'b1, 8'd20, 4'b0000);
        step(1'b1, 8'd30, 4'b0000);
        step(1'b1, 8'd40, 4'b0000);
        check("deal_ptr0", 32'(dbg_ptr), 32'd0);
        step(1'b0, 8'd0, 4'b1111);
        check("deal_a", 32'(a), 32'd10);
        check("deal_b", 32'(b), 32'd20);
        check("deal_c", 32'(c), 32'd30);
        check("deal_d", 32'(d), 32'd40);
        check("deal_valid", 32'(valid), 32'hf);
        step(1'b0, 8'd0, 4'b0000);
        check("deal_valid_drop", 32'(valid), 32'd0);
        check("deal_a_hold", 32'(a), 32'd10);

        // fill all four FIFOs
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 4'b0000);
            check("fill_ready", 32'(ready), (i < 16) ? 32'd1 : 32'd0);
        end
        step(1'b1, 8'd17, 4'b0000);
        check("drop_error", 32'(error), 32'd1);
        check("drop_ptr", 32'(dbg_ptr), 32'd0);
        step(1'b0, 8'd0, 4'b0000);
        check("drop_error_clear", 32'(error), 32'd0);

        // skip full: free one slot in C, then write lands there
        step(1'b0, 8'd0, 4'b0100);
        check("skip_c_read", 32'(c), 32'd3);
        check("skip_c_valid", 32'(valid), 32'b0100);
        check("skip_ready", 32'(ready), 32'd1);
        step(1'b1, 8'd99, 4'b0000);
        check("skip_ptr", 32'(dbg_ptr), 32'd3);
        check("skip_no_error", 32'(error), 32'd0);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 8'd0, 4'b0001);
            check("drain_a", 32'(a), 32'(1 + 4 * j));
            check("drain_a_valid", 32'(valid), 32'b0001);
        end
        exp_c[0] = 8'd7;
        exp_c[1] = 8'd11;
        exp_c[2] = 8'd15;
        exp_c[3] = 8'd99;
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 8'd0, 4'b0100);
            check("drain_c", 32'(c), 32'(exp_c[j]));
        end
        step(1'b0, 8'd0, 4'b0100);
        check("c_empty_valid", 32'(valid), 32'd0);
        check("c_empty_data", 32'(c), 32'd0);

        // simultaneous read of full A with a write
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 4'b0000);
        end
        step(1'b0, 8'd0, 4'b0010);
        check("sim_b_read", 32'(b), 32'd2);
        step(1'b1, 8'd55, 4'b0001);
        check("sim_a_pop", 32'(a), 32'd1);
        check("sim_valid", 32'(valid), 32'b0001);
        check("sim_ptr", 32'(dbg_ptr), 32'd2);
        exp_b[0] = 8'd6;
        exp_b[1] = 8'd10;
        exp_b[2] = 8'd14;
        exp_b[3] = 8'd55;
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 8'd0, 4'b0010);
            check("sim_drain_b", 32'(b), 32'(exp_b[j]));
        end

        // asynchronous reset mid-operation
        do_reset();
        step(1'b1, 8'd87, 4'b0000);
        step(1'b1, 8'd56, 4'b0000);
        step(1'b1, 8'd9, 4'b0000);
        step(1'b1, 8'd13, 4'b0001);
        check("pre_rst_valid", 32'(valid), 32'b0001);
        wen = 1'b0;
        ren = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_ptr", 32'(dbg_ptr), 32'd0);
        check("mid_rst_a", 32'(a), 32'd0);
        #9;
        rst_n = 1'b1;
        step(1'b1, 8'd51, 4'b0000);
        check("post_rst_ptr", 32'(dbg_ptr), 32'd1);
        step(1'b0, 8'd0, 4'b0001);
        check("post_rst_a", 32'(a), 32'd51);
        check("post_rst_valid", 32'(valid), 32'b0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/round_robin_fifo_distributor.md
# round_robin_fifo_distributor

Write-side counterpart of the round-robin FIFO arbiter. It takes a single input byte stream and deals the words out round-robin into four per-channel FIFOs, skipping any channel whose FIFO is full. Each channel has its own read enable and its own registered output. It sits upstream of per-channel consumers, and is the mirror image of the arbiter, which merges four FIFOs into one stream.

## Interface
Parameters:
- DATA_W, 8, data word width
- DEPTH, 4, entries per channel FIFO; power of two, ≥2

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wen  in  1  write request for din this cycle
- din  in  DATA_W  input word
- ren  in  4  per-channel read enable; bit 0 = A … bit 3 = D
- a, b, c, d  out  DATA_W  registered read data for channels A–D
- valid  out  4  per-channel read-data-valid, registered
- ready  out  1  combinational; 1 when at least one channel FIFO is not full
- error  out  1  registered one-cycle pulse: write dropped because all FIFOs were full

## Operation
- Distribution state:
  - 2-bit pointer `ptr` names the next target channel; reset value 0.
  - On wen=1, select the first non-full channel scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Push din into the selected channel and set ptr = selected+1 (mod 4).
  - If all four FIFOs are full: drop the word, leave ptr unchanged, assert error on the next cycle.
  - wen=0: no push, ptr unchanged.
- Full/empty are evaluated on the state before the clock edge.
  - A write to a full FIFO is skipped even if the same channel is read in that cycle. The scan moves on to the next channel.
  - A read of an empty FIFO returns nothing, even if the same cycle's write targets that channel. The written word still lands.
- Per-channel read, independent for each of the four channels:
  - ren[i]=1 and FIFO i non-empty: pop the head into output register i and set valid[i]=1.
  - ren[i]=1 and FIFO i empty: output register i = 0 and valid[i]=0.
  - ren[i]=0: valid[i]=0; output register i holds its last value.
- Multiple channels may be read in the same cycle. Reads and the single write may occur together.
- Each FIFO has a count in 0..DEPTH. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Reset (asynchronous, any time, including mid-operation):
  - All FIFOs emptied, ptr=0.
  - a=b=c=d=0, valid=0, error=0.
  - ready=1 once reset has applied.

## Timing
- Write accepted at edge N is readable by ren asserted in the cycle after edge N. Its data appears on the output after edge N+1 (minimum one-cycle write-to-read latency).
- Read latency: ren sampled at edge M gives data/valid after edge M. Valid is high for exactly one cycle per pop.
- error asserts after the edge that dropped the write, for one cycle per dropped write.
- ready depends only on registered counts; there is no combinational path from wen/ren to ready.
- Throughput: one write per cycle, plus one read per channel per cycle.

## Structure
- Shared package rr_dist_pkg:
  - NUM_CH=4
  - channel index width CH_W=2
  - channel encodings CH_A..CH_D (0..3)
- One sub-module, rr_fifo_channel, instantiated four times.
  - Parameterised by DATA_W and DEPTH.
  - Ports: push, push_data, pop, pop_data, pop_valid, full, empty.
- Top level holds ptr, the skip-full priority scan, ready, error, and the output mapping to a/b/c/d.

## Test plan
- Basic deal: after reset, write 10, 20, 30, 40 on consecutive cycles; then ren=4'b1111 for one cycle -> a=10, b=20, c=30, d=40, valid=4'b1111 for one cycle.
- Empty read: right after reset, ren=4'b0001 -> valid=4'b0000, a=0.
- Full/drop: write 1..16 (ready=1 throughout, ready=0 after the 16th); write 17 -> error=1 for one cycle and ptr stays 0. Then drain A with 4 reads -> 1, 5, 9, 13 in order.
- Skip full: all FIFOs full, ptr=0; read C once (gets 3); write 99 -> lands in C (A and B skipped), ptr=3. A subsequent C read after draining 7, 11, 15 returns 99.
- Simultaneous edge: A full, ptr=0, wen=1 with din=55 and ren=4'b0001 in the same cycle -> A pops its head, 55 goes to B, ptr=2.
- Reset mid-operation: after writing 87, 56, 9, 13, pulse rst_n low for 10 ns -> valid=0, error=0, ready=1. The next write of 51 lands in A, and ren=4'b0001 returns a=51.
